// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary exponentiation controller driving an external
// Montgomery multiplier: one squaring per exponent bit, one extra multiply
// per set bit, then a final multiply by 1 to leave the Montgomery domain.
module mont_exp_ctrl #(
    parameter int unsigned EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [1023:0]        in_x,
    input  logic [1023:0]        in_r,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [1023:0]        in_m,
    output logic [1023:0]        result,
    output logic                 done,
    output logic                 mm_start,
    output logic [1023:0]        mm_a,
    output logic [1023:0]        mm_b,
    output logic [1023:0]        mm_m,
    input  logic [1023:0]        mm_result,
    input  logic                 mm_done
);

    localparam int unsigned DW = 1024;
    localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [3:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        NEXT,
        CONV_ISSUE,
        CONV_WAIT,
        FIN
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [DW-1:0]        x_q;
    logic [DW-1:0]        acc_q;
    logic [DW-1:0]        res_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic [IW-1:0]        idx_q;

    assign mm_m   = in_m;
    assign mm_a   = acc_q;
    assign result = res_q;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state decode plus the per-state multiplier controls
    always_comb begin
        state_nx = state;
        mm_start = 1'b0;
        done     = 1'b0;
        mm_b     = '0;
        unique case (state)
            IDLE:       if (start) state_nx = SQ_ISSUE;
            SQ_ISSUE: begin
                mm_start = 1'b1;
                mm_b     = acc_q;
                state_nx = SQ_WAIT;
            end
            SQ_WAIT: begin
                mm_b = acc_q;
                if (mm_done) state_nx = e_q[idx_q] ? MUL_ISSUE : NEXT;
            end
            MUL_ISSUE: begin
                mm_start = 1'b1;
                mm_b     = x_q;
                state_nx = MUL_WAIT;
            end
            MUL_WAIT: begin
                mm_b = x_q;
                if (mm_done) state_nx = NEXT;
            end
            NEXT:       state_nx = (idx_q == '0) ? CONV_ISSUE : SQ_ISSUE;
            CONV_ISSUE: begin
                mm_start = 1'b1;
                mm_b     = {{(DW-1){1'b0}}, 1'b1};
                state_nx = CONV_WAIT;
            end
            CONV_WAIT: begin
                mm_b = {{(DW-1){1'b0}}, 1'b1};
                if (mm_done) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default:    state_nx = IDLE;
        endcase
    end

    // Operand latch, accumulator, bit index and result register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q   <= '0;
            e_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            idx_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x_q   <= in_x;
                    e_q   <= in_e;
                    acc_q <= in_r;
                    idx_q <= IW'(EXP_WIDTH - 1);
                end
                SQ_WAIT, MUL_WAIT: if (mm_done) acc_q <= mm_result;
                NEXT:      if (idx_q != '0) idx_q <= idx_q - IW'(1);
                CONV_WAIT: if (mm_done) res_q <= mm_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
module tb_mont_exp_ctrl;

    localparam int unsigned EW = 8;
    localparam int unsigned DW = 1024;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_x = '0, in_r = '0, in_m = '0;
    logic [EW-1:0] in_e = '0;
    logic [DW-1:0] result, mm_a, mm_b, mm_m;
    logic [DW-1:0] mm_result = '0;
    logic          done, mm_start;
    logic          mm_done = 1'b0;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.EXP_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_m(in_m),
        .result(result), .done(done), .mm_start(mm_start),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    typedef struct {
        logic [DW-1:0] res;
        int unsigned   pulses;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    bit          mont_mode = 0;
    int unsigned lat_lo = 5, lat_hi = 5;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h need %0h (low 192 bits)", name, act[191:0], req[191:0]);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [DW-1:0] plain_mul(input logic [DW-1:0] a, b, m);
        logic [2*DW-1:0] p;
        p = ({{DW{1'b0}}, a} * {{DW{1'b0}}, b}) % {{DW{1'b0}}, m};
        return p[DW-1:0];
    endfunction

    // a*b*2^-DW mod m, radix-2 Montgomery (m odd)
    function automatic logic [DW-1:0] mont_mul(input logic [DW-1:0] a, b, m);
        logic [DW+1:0] t;
        t = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[DW-1:0];
    endfunction

    // x^e mod m by repeated multiplication
    function automatic logic [DW-1:0] ref_pow(input logic [DW-1:0] x, input logic [EW-1:0] e,
                                               input logic [DW-1:0] m);
        logic [2*DW-1:0] r, mm;
        mm = {{DW{1'b0}}, m};
        r  = 1;
        r  = r % mm;
        for (int unsigned i = 0; i < e; i++) r = (r * {{DW{1'b0}}, x}) % mm;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int unsigned i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- mock multiplier ----------------
    logic [DW-1:0] cap_a, cap_b, prod;
    int unsigned   lat = 0;
    bit            busy = 0, cap_ok = 0;

    // Serves one request at a time; keeps running through a DUT reset so a
    // stale completion pulse reaches the idle controller.
    always @(negedge clk) begin
        mm_done = 1'b0;
        if (!resetn) cap_ok = 0;
        if (busy) begin
            if (lat <= 1) begin
                busy      = 0;
                mm_done   = 1'b1;
                mm_result = prod;
                if (cap_ok) begin
                    check("mm_a_hold", mm_a, cap_a);
                    check("mm_b_hold", mm_b, cap_b);
                end
            end else begin
                lat--;
            end
        end else if (mm_start && resetn) begin
            cap_a  = mm_a;
            cap_b  = mm_b;
            cap_ok = 1;
            busy   = 1;
            lat    = $urandom_range(lat_hi, lat_lo);
            check("mm_m", mm_m, in_m);
            prod = mont_mode ? mont_mul(mm_a, mm_b, mm_m) : plain_mul(mm_a, mm_b, mm_m);
        end
    end

    // ---------------- scoreboard monitor ----------------
    int unsigned pulse_cnt = 0;
    bit          prev_done = 0;

    always @(negedge clk) begin
        exp_t ex;
        if (!resetn) begin
            pulse_cnt = 0;
            prev_done = 0;
        end else begin
            if (prev_done) check("done_one_cycle", DW'(done), DW'(0));
            if (mm_start) pulse_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    ex = sb.pop_front();
                    check("result", result, ex.res);
                    check("mm_start_count", DW'(pulse_cnt), DW'(ex.pulses));
                end
                pulse_cnt = 0;
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic [DW-1:0] x, input logic [EW-1:0] e,
                          input logic [DW-1:0] m, input bit push);
        logic [2*DW-1:0] t;
        logic [DW-1:0]   ix, ir;
        exp_t            ex;
        if (mont_mode) begin
            t  = {x, {DW{1'b0}}} % {{DW{1'b0}}, m};
            ix = t[DW-1:0];
            t  = {{(DW-1){1'b0}}, 1'b1, {DW{1'b0}}} % {{DW{1'b0}}, m};
            ir = t[DW-1:0];
        end else begin
            ix = x;
            ir = 1;
        end
        ex.res    = ref_pow(x, e, m);
        ex.pulses = EW + $countones(e) + 1;
        @(negedge clk);
        in_x = ix; in_r = ir; in_e = e; in_m = m; start = 1'b1;
        if (push) sb.push_back(ex);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail_now("done_timeout");
    endtask

    initial begin
        logic [DW-1:0] m, x;
        logic [EW-1:0] e;
        int unsigned   seen, k;

        #2;
        check("rst_result", result, '0);
        check("rst_done", DW'(done), DW'(0));
        check("rst_mm_start", DW'(mm_start), DW'(0));
        check("rst_mm_a", mm_a, '0);
        check("rst_mm_b", mm_b, '0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // basic cases, mock returns a*b mod m after 5 cycles, R = 1
        run_op(2, 8'h05, 13, 1); wait_done(500);
        repeat (2) @(negedge clk);
        run_op(7, 8'h00, 13, 1); wait_done(500);
        repeat (2) @(negedge clk);
        run_op(2, 8'hB5, 13, 1); wait_done(500);
        // back-to-back: second start in the cycle after done
        run_op(3, 8'h04, 13, 1); wait_done(500);
        run_op(5, 8'h02, 13, 1); wait_done(500);
        repeat (2) @(negedge clk);

        // start pulsed during SQ_WAIT with different operands is ignored
        run_op(6, 8'h3C, 13, 1);
        @(negedge clk);
        in_x = 11; in_e = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(500);
        repeat (2) @(negedge clk);

        // reset during MUL_WAIT: second issue is the multiply by x (e[7]=1)
        run_op(7, 8'h80, 13, 0);
        seen = 0; k = 0;
        while (seen < 2 && k < 200) begin
            if (mm_start) seen++;
            if (seen < 2) begin @(negedge clk); k++; end
        end
        if (seen < 2) fail_now("mul_issue_timeout");
        check("mul_b_is_x", mm_b, 7);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort_done", DW'(done), DW'(0));
        check("abort_mm_start", DW'(mm_start), DW'(0));
        check("abort_result", result, '0);
        check("abort_mm_a", mm_a, '0);
        check("abort_mm_b", mm_b, '0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        check("after_stale_done_result", result, '0);
        run_op(7, 8'h80, 13, 1); wait_done(500);
        repeat (2) @(negedge clk);

        // randomized small-modulus ops with random multiplier latency
        lat_lo = 1; lat_hi = 6;
        for (int i = 0; i < 6; i++) begin
            m = DW'($urandom_range(127, 1) * 2 + 1);
            x = DW'($urandom) % m;
            e = EW'($urandom);
            run_op(x, e, m, 1);
            wait_done(1000);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        // full-width Montgomery multiplier
        mont_mode = 1;
        for (int i = 0; i < 2; i++) begin
            m = rand_wide();
            m[DW-1] = 1'b1;
            m[0] = 1'b1;
            x = rand_wide() % m;
            e = EW'($urandom);
            run_op(x, e, m, 1);
            wait_done(2000);
            repeat (2) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", DW'(sb.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameter: EXP_WIDTH, 1024, number of exponent bits scanned (MSB first).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: resetn  input  1  asynchronous active-low reset; one clock; no other clock domains.
REQ-004 SHALL have port: start  input  1  one-cycle request, sampled only in IDLE.
REQ-005 SHALL have port: in_x  input  1024  base in Montgomery domain (x*R mod M).
REQ-006 SHALL have port: in_r  input  1024  R mod M (Montgomery one), initial accumulator.
REQ-007 SHALL have port: in_e  input  EXP_WIDTH  exponent.
REQ-008 SHALL have port: in_m  input  1024  modulus, odd, stable from start until done.
REQ-009 SHALL have port: result  output  1024  x^e mod M in normal domain.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port: mm_start  output  1  one-cycle start to downstream Montgomery multiplier.
REQ-012 SHALL have ports: mm_a, mm_b, mm_m  output  1024 each  multiplier operands.
REQ-013 SHALL have port: mm_result  input  1024  multiplier product a*b*R^-1 mod M.
REQ-014 SHALL have port: mm_done  input  1  multiplier completion pulse.

Function
REQ-015 SHALL latch in_x, in_r, in_e into internal registers on the cycle start is seen in IDLE; acc <= in_r, bit index <= EXP_WIDTH-1.
REQ-016 SHALL implement states IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, CONV_ISSUE, CONV_WAIT, FIN.
REQ-017 SHALL transition IDLE->SQ_ISSUE on start; SQ_ISSUE->SQ_WAIT; SQ_WAIT->(MUL_ISSUE if e[idx]=1 else NEXT) on mm_done; MUL_ISSUE->MUL_WAIT; MUL_WAIT->NEXT on mm_done.
REQ-018 SHALL in NEXT go to CONV_ISSUE if idx=0, else decrement idx and go to SQ_ISSUE.
REQ-019 SHALL transition CONV_ISSUE->CONV_WAIT; CONV_WAIT->FIN on mm_done; FIN->IDLE.
REQ-020 SHALL assert mm_start for exactly one cycle in each *_ISSUE state and never elsewhere.
REQ-021 SHALL drive mm_a=mm_b=acc in SQ states; mm_a=acc, mm_b=x in MUL states; mm_a=acc, mm_b=1 in CONV states; values held constant from ISSUE through the cycle mm_done is seen.
REQ-022 SHALL drive mm_m = in_m continuously.
REQ-023 SHALL load acc <= mm_result on the mm_done cycle in SQ_WAIT/MUL_WAIT; in CONV_WAIT load result register <= mm_result.
REQ-024 SHALL assert done for one cycle in FIN; result held until the next CONV_WAIT load.
REQ-025 SHALL issue exactly EXP_WIDTH + popcount(e) + 1 multiplications per operation.
REQ-026 SHALL ignore start outside IDLE and ignore mm_done outside *_WAIT states.
REQ-027 SHALL handle e=0 giving result = MM(R,1) = 1; leading zero bits are processed (squarings of R), not skipped.
REQ-028 SHALL accept start in the cycle after FIN (back-to-back operations).

Reset
REQ-029 SHALL on resetn=0, immediately and asynchronously: state=IDLE, done=0, mm_start=0, result=0, acc=0, idx=0, latched operands=0.
REQ-030 SHALL on reset mid-operation abandon the operation with no done pulse; a later mm_done is ignored in IDLE.

Verification
REQ-031 SHALL cover (mock multiplier returns a*b mod m after 5 cycles, in_r=1, EXP_WIDTH=8): m=13, x=2, e=5 -> result=6, done one pulse.
REQ-032 SHALL cover e=0x00, m=13, x=7 -> result=1 after exactly 9 mm_start pulses.
REQ-033 SHALL cover e=0xB5 -> exactly 14 mm_start pulses; mm_a/mm_b stable between each mm_start and mm_done.
REQ-034 SHALL cover start pulsed during SQ_WAIT -> no effect; resetn low during MUL_WAIT -> outputs 0 immediately, no done, next start completes correctly.
REQ-035 SHALL cover two back-to-back ops (x=3,e=4,m=13 -> 3; then x=5,e=2,m=13 -> 12) with start in the cycle after done.
REQ-036 SHALL cover integration with the real 1024-bit Montgomery multiplier: random odd M, random x, e -> result equals reference model x^e mod M.
